// File: rtl/wb_stage_if.sv
// Bundle between the memory stage, data memory response and register file write
// port of the RV32I writeback stage; master drives instructions, slave is the stage.
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rd;
  logic             in_regwrite;
  logic [31:0]      in_result;
  logic             in_is_load;
  logic [2:0]       in_funct3;
  logic [1:0]       in_addr_lo;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;
  logic [4:0]       WriteReg;
  logic [31:0]      WriteData;
  logic             RegWrite;
  logic             load_err;
  logic [CNT_W-1:0] instret;

  modport master (
    output in_valid, in_rd, in_regwrite, in_result, in_is_load, in_funct3, in_addr_lo,
    output mem_rvalid, mem_rdata,
    input  in_ready, WriteReg, WriteData, RegWrite, load_err, instret
  );

  modport slave (
    input  in_valid, in_rd, in_regwrite, in_result, in_is_load, in_funct3, in_addr_lo,
    input  mem_rvalid, mem_rdata,
    output in_ready, WriteReg, WriteData, RegWrite, load_err, instret
  );
endinterface

// File: rtl/wb_stage.sv
// RV32I writeback stage: waits for load data, aligns/extends it, flags faulting
// loads and drives a registered register-file write port plus retire counter.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_t;

  state_t           r_state;
  logic [4:0]       r_rd;
  logic             r_regwrite;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [4:0]       r_write_reg;
  logic [31:0]      r_write_data;
  logic             r_reg_write;
  logic             r_load_err;
  logic [CNT_W-1:0] r_instret;

  logic w_ready;
  logic w_accept;
  logic w_in_fault;

  function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] b);
    logic fault;
    case (f3)
      3'b000, 3'b100: fault = 1'b0;
      3'b001, 3'b101: fault = b[0];
      3'b010:         fault = (b != 2'b00);
      default:        fault = 1'b1;
    endcase
    return fault;
  endfunction

  function automatic logic [31:0] format_load(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] b);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    case (b)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = b[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{byte_v[7]}}, byte_v};
      3'b100:  res = {24'h000000, byte_v};
      3'b001:  res = {{16{half_v[15]}}, half_v};
      3'b101:  res = {16'h0000, half_v};
      default: res = word;
    endcase
    return res;
  endfunction

  assign w_ready    = (r_state != S_WAIT_MEM);
  assign w_accept   = bus.in_valid && w_ready;
  assign w_in_fault = bus.in_is_load && load_fault(bus.in_funct3, bus.in_addr_lo);

  assign bus.in_ready  = w_ready;
  assign bus.WriteReg  = r_write_reg;
  assign bus.WriteData = r_write_data;
  assign bus.RegWrite  = r_reg_write;
  assign bus.load_err  = r_load_err;
  assign bus.instret   = r_instret;

  // State machine with registered write-port outputs; non-loads and faults write on the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_rd         <= 5'd0;
      r_regwrite   <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr_lo    <= 2'd0;
      r_write_reg  <= 5'd0;
      r_write_data <= 32'd0;
      r_reg_write  <= 1'b0;
      r_load_err   <= 1'b0;
      r_instret    <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE, S_WRITE: begin
          if (w_accept) begin
            r_rd       <= bus.in_rd;
            r_regwrite <= bus.in_regwrite;
            r_funct3   <= bus.in_funct3;
            r_addr_lo  <= bus.in_addr_lo;
            if (bus.in_is_load && !w_in_fault) begin
              r_state     <= S_WAIT_MEM;
              r_reg_write <= 1'b0;
              r_load_err  <= 1'b0;
            end else begin
              r_state      <= S_WRITE;
              r_write_reg  <= bus.in_rd;
              r_write_data <= bus.in_result;
              r_reg_write  <= bus.in_regwrite && (bus.in_rd != 5'd0) && !w_in_fault;
              r_load_err   <= w_in_fault;
              r_instret    <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            r_state     <= S_IDLE;
            r_reg_write <= 1'b0;
            r_load_err  <= 1'b0;
          end
        end
        S_WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            r_state      <= S_WRITE;
            r_write_reg  <= r_rd;
            r_write_data <= format_load(bus.mem_rdata, r_funct3, r_addr_lo);
            r_reg_write  <= r_regwrite && (r_rd != 5'd0);
            r_load_err   <= 1'b0;
            r_instret    <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            r_state     <= S_WAIT_MEM;
            r_reg_write <= 1'b0;
            r_load_err  <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_reg_write <= 1'b0;
          r_load_err  <= 1'b0;
        end
      endcase
    end
  end
endmodule
